// File: rtl/udp_port_drain_arbiter.sv
// Packet-atomic round-robin drain of the per-port UDP payload byte FIFOs onto a
// single port-tagged byte stream, with forced truncation of over-long packets.
module udp_port_drain_arbiter #(
    parameter int P_NUM_PORTS     = 2,
    parameter int P_MAX_PKT_BYTES = 1472,
    parameter int P_IDX_W         = (P_NUM_PORTS > 1) ? $clog2(P_NUM_PORTS) : 1
) (
    input  logic                     i_rxmac_clk,
    input  logic                     i_rxmac_srst,
    input  logic                     i_en,
    input  logic [P_NUM_PORTS-1:0]   i_port_pkt_avail,
    input  logic [8*P_NUM_PORTS-1:0] i_port_byte,
    input  logic [P_NUM_PORTS-1:0]   i_port_byte_vld,
    input  logic [P_NUM_PORTS-1:0]   i_port_eop,
    output logic [P_NUM_PORTS-1:0]   o_port_byte_rd,
    output logic [7:0]               o_byte,
    output logic                     o_byte_vld,
    output logic                     o_byte_sop,
    output logic                     o_byte_eop,
    output logic [P_IDX_W-1:0]       o_byte_port,
    input  logic                     i_byte_rdy,
    output logic                     o_pkt_trunc,
    output logic                     o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARB,
        ST_XFER,
        ST_DROP
    } state_t;

    localparam logic [15:0]        CNT_LAST = 16'(P_MAX_PKT_BYTES - 1);
    localparam logic [P_IDX_W-1:0] RR_INIT  = P_IDX_W'(P_NUM_PORTS - 1);

    state_t             state, state_d;
    logic [P_IDX_W-1:0] grant, grant_d;
    logic [P_IDX_W-1:0] rr_ptr, rr_ptr_d;
    logic [15:0]        byte_cnt, byte_cnt_d;
    logic               sop_pend, sop_pend_d;

    logic [7:0]         g_byte;
    logic               g_vld;
    logic               g_eop;
    logic               rd_g;

    logic               arb_found;
    logic [P_IDX_W-1:0] arb_idx;
    int                 cand;
    logic               cand_avail;

    // Head of the granted FIFO; a compare-per-port mux keeps index widths exact.
    always_comb begin
        g_byte = '0;
        g_vld  = 1'b0;
        g_eop  = 1'b0;
        for (int p = 0; p < P_NUM_PORTS; p++) begin
            if (grant == P_IDX_W'(p)) begin
                g_byte = i_port_byte[8*p +: 8];
                g_vld  = i_port_byte_vld[p];
                g_eop  = i_port_eop[p];
            end
        end
    end

    // Search rr_ptr+1, rr_ptr+2, ... so the last-served port has lowest priority.
    always_comb begin
        arb_found  = 1'b0;
        arb_idx    = '0;
        cand       = 0;
        cand_avail = 1'b0;
        for (int k = 1; k <= P_NUM_PORTS; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= P_NUM_PORTS) begin
                cand = cand - P_NUM_PORTS;
            end
            cand_avail = 1'b0;
            for (int p = 0; p < P_NUM_PORTS; p++) begin
                if (cand == p) begin
                    cand_avail = i_port_pkt_avail[p];
                end
            end
            if (!arb_found && cand_avail) begin
                arb_found = 1'b1;
                arb_idx   = P_IDX_W'(cand);
            end
        end
    end

    // NOTE: every output and next-state value gets a default before the case,
    // so no path through this block can leave a value held (no latch).
    always_comb begin
        state_d     = state;
        grant_d     = grant;
        rr_ptr_d    = rr_ptr;
        byte_cnt_d  = byte_cnt;
        sop_pend_d  = sop_pend;
        rd_g        = 1'b0;
        o_byte      = '0;
        o_byte_vld  = 1'b0;
        o_byte_sop  = 1'b0;
        o_byte_eop  = 1'b0;
        o_byte_port = '0;
        o_pkt_trunc = 1'b0;

        case (state)
            ST_IDLE: begin
                if (i_en && (|i_port_pkt_avail)) begin
                    state_d = ST_ARB;
                end
            end

            ST_ARB: begin
                if (arb_found) begin
                    grant_d    = arb_idx;
                    rr_ptr_d   = arb_idx;
                    byte_cnt_d = '0;
                    sop_pend_d = 1'b1;
                    state_d    = ST_XFER;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_XFER: begin
                o_byte      = g_byte;
                o_byte_vld  = g_vld;
                o_byte_port = grant;
                o_byte_sop  = sop_pend;
                o_byte_eop  = g_eop || (byte_cnt == CNT_LAST);
                if (g_vld && i_byte_rdy) begin
                    rd_g       = 1'b1;
                    sop_pend_d = 1'b0;
                    if (byte_cnt != 16'hFFFF) begin
                        byte_cnt_d = byte_cnt + 16'd1;
                    end
                    // A real eop on the last allowed byte is a normal end.
                    if (g_eop) begin
                        state_d = ST_IDLE;
                    end else if (byte_cnt == CNT_LAST) begin
                        o_pkt_trunc = 1'b1;
                        state_d     = ST_DROP;
                    end
                end
            end

            ST_DROP: begin
                rd_g = g_vld;
                if (g_vld && g_eop) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_port_byte_rd = '0;
        for (int p = 0; p < P_NUM_PORTS; p++) begin
            if (grant == P_IDX_W'(p)) begin
                o_port_byte_rd[p] = rd_g;
            end
        end
    end

    assign o_busy = (state != ST_IDLE);

    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge i_rxmac_clk or negedge i_rxmac_srst) begin
        if (!i_rxmac_srst) begin
            state    <= ST_IDLE;
            grant    <= '0;
            rr_ptr   <= RR_INIT;
            byte_cnt <= '0;
            sop_pend <= 1'b0;
        end else begin
            state    <= state_d;
            grant    <= grant_d;
            rr_ptr   <= rr_ptr_d;
            byte_cnt <= byte_cnt_d;
            sop_pend <= sop_pend_d;
        end
    end

endmodule

// File: tb/tb_udp_port_drain_arbiter.sv
// Randomized bench for udp_port_drain_arbiter: two instances (2 ports / 1472-byte
// limit, 3 ports / 8-byte limit) fed from queue FIFO models, checked per packet.
`timescale 1ns/1ps
module tb_udp_port_drain_arbiter;

    localparam int MAX0 = 1472;
    localparam int MAX1 = 8;

    function automatic int np_of(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic int mx_of(input int d);
        return (d == 0) ? MAX0 : MAX1;
    endfunction

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en     [2];
    logic        rdy    [2];
    logic [2:0]  avail  [2];
    logic [2:0]  vld    [2];
    logic [2:0]  eop    [2];
    logic [23:0] pbyte  [2];

    wire  [1:0]  rd0;
    wire  [2:0]  rd1;
    wire         oport0;
    wire  [1:0]  oport1;
    wire  [2:0]  rd     [2];
    wire  [1:0]  oport  [2];
    wire  [7:0]  ob     [2];
    wire         ovld   [2];
    wire         osop   [2];
    wire         oeop   [2];
    wire         otrunc [2];
    wire         obusy  [2];

    assign rd[0]    = {1'b0, rd0};
    assign rd[1]    = rd1;
    assign oport[0] = {1'b0, oport0};
    assign oport[1] = oport1;

    // FIFO model: entries are {eop, byte}; index = dut*3 + port.
    logic [8:0]  fq      [6][$];
    int          pkts    [6];
    int          pops    [6];
    logic [7:0]  mbytes  [6][$];
    int          mlen    [6][$];
    int          last    [2];
    logic [12:0] exp_q   [2][$];
    logic [12:0] obs     [2][$];
    int          obs_cyc [2][$];
    int          rdy_mode  [2];
    bit          vld_noise [2];
    logic [2:0]  rd_s    [2];
    int          cyc;
    int          checks;
    int          errors;

    always #5 clk = ~clk;

    udp_port_drain_arbiter #(.P_NUM_PORTS(2), .P_MAX_PKT_BYTES(MAX0)) dut0 (
        .i_rxmac_clk(clk), .i_rxmac_srst(rst_n), .i_en(en[0]),
        .i_port_pkt_avail(avail[0][1:0]), .i_port_byte(pbyte[0][15:0]),
        .i_port_byte_vld(vld[0][1:0]), .i_port_eop(eop[0][1:0]),
        .o_port_byte_rd(rd0), .o_byte(ob[0]), .o_byte_vld(ovld[0]),
        .o_byte_sop(osop[0]), .o_byte_eop(oeop[0]), .o_byte_port(oport0),
        .i_byte_rdy(rdy[0]), .o_pkt_trunc(otrunc[0]), .o_busy(obusy[0]));

    udp_port_drain_arbiter #(.P_NUM_PORTS(3), .P_MAX_PKT_BYTES(MAX1)) dut1 (
        .i_rxmac_clk(clk), .i_rxmac_srst(rst_n), .i_en(en[1]),
        .i_port_pkt_avail(avail[1]), .i_port_byte(pbyte[1]),
        .i_port_byte_vld(vld[1]), .i_port_eop(eop[1]),
        .o_port_byte_rd(rd1), .o_byte(ob[1]), .o_byte_vld(ovld[1]),
        .o_byte_sop(osop[1]), .o_byte_eop(oeop[1]), .o_byte_port(oport1),
        .i_byte_rdy(rdy[1]), .o_pkt_trunc(otrunc[1]), .o_busy(obusy[1]));

    task automatic refresh_heads();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 3; p++) begin
                int q;
                q = d*3 + p;
                if (fq[q].size() > 0 && !(vld_noise[d] && $urandom_range(3) == 0)) begin
                    vld[d][p]          = 1'b1;
                    pbyte[d][8*p +: 8] = fq[q][0][7:0];
                    eop[d][p]          = fq[q][0][8];
                end else begin
                    vld[d][p]          = 1'b0;
                    pbyte[d][8*p +: 8] = 8'($urandom);
                    eop[d][p]          = 1'($urandom);
                end
                avail[d][p] = (pkts[q] > 0);
            end
        end
    endtask

    // Pops are taken from the strobe seen mid-cycle and applied just after the edge.
    always begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) rd_s[d] = rd[d];
        @(posedge clk);
        cyc++;
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 3; p++) begin
                int q;
                logic [8:0] e;
                q = d*3 + p;
                if (rd_s[d][p] && fq[q].size() > 0) begin
                    e = fq[q].pop_front();
                    pops[q]++;
                    if (e[8]) pkts[q]--;
                end
            end
            case (rdy_mode[d])
                0:       rdy[d] = 1'b1;
                1:       rdy[d] = !rdy[d];
                default: rdy[d] = 1'($urandom_range(1));
            endcase
        end
        refresh_heads();
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ovld[d] && rdy[d]) begin
                obs[d].push_back({otrunc[d], osop[d], oeop[d], oport[d], ob[d]});
                obs_cyc[d].push_back(cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_pkt(input int d, input int p, input int len, input bit ramp);
        int q;
        logic [7:0] b;
        q = d*3 + p;
        for (int i = 0; i < len; i++) begin
            b = ramp ? 8'(i) : 8'($urandom);
            fq[q].push_back({(i == len-1), b});
            mbytes[q].push_back(b);
        end
        mlen[q].push_back(len);
        pkts[q]++;
    endtask

    // Expected stream: round-robin over ports with pending packets, each packet
    // cut to the length limit.
    task automatic build_expected(input int d);
        int np, mx, sel, len, q, c;
        bit found;
        logic [7:0] b;
        np = np_of(d);
        mx = mx_of(d);
        forever begin
            found = 0;
            sel   = 0;
            for (int k = 1; k <= np; k++) begin
                c = (last[d] + k) % np;
                if (!found && mlen[d*3 + c].size() > 0) begin
                    found = 1;
                    sel   = c;
                end
            end
            if (!found) break;
            q   = d*3 + sel;
            len = mlen[q].pop_front();
            for (int i = 0; i < len; i++) begin
                b = mbytes[q].pop_front();
                if (i < mx)
                    exp_q[d].push_back({(i == mx-1 && len > mx), (i == 0),
                                        (i == len-1 || i == mx-1), 2'(sel), b});
            end
            last[d] = sel;
        end
    endtask

    task automatic wait_obs(input int d, input int n, input int budget, output bit ok);
        for (int t = 0; t < budget && obs[d].size() < n; t++) @(posedge clk);
        ok = (obs[d].size() >= n);
    endtask

    task automatic wait_idle(input int d, input int budget, output bit ok);
        bit empty;
        ok = 0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            empty = 1;
            for (int p = 0; p < 3; p++) if (fq[d*3 + p].size() > 0) empty = 0;
            if (empty && !obusy[d]) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic clear_obs(input int d);
        obs[d].delete();
        obs_cyc[d].delete();
        exp_q[d].delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({ob[d], ovld[d], osop[d], oeop[d], oport[d], otrunc[d], obusy[d], rd[d]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got byte=%h vld=%b busy=%b rd=%b, want all 0",
                         d, ob[d], ovld[d], obusy[d], rd[d]);
            end
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obusy[d] !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset dut%0d: busy=%b want 0", d, obusy[d]);
            end
        end
    endtask

    task automatic test_single_pkt();
        bit ok;
        int p0;
        @(posedge clk); #2;
        p0 = pops[0];
        load_pkt(0, 0, 10, 1'b1);
        refresh_heads();
        build_expected(0);
        wait_obs(0, 10, 100, ok);
        wait_idle(0, 100, ok);
        checks++;
        if (obs[0].size() != 10) begin
            errors++;
            $display("FAIL single_count: got %0d bytes want 10", obs[0].size());
        end
        for (int i = 0; i < exp_q[0].size(); i++) begin
            logic [12:0] got;
            got = (i < obs[0].size()) ? obs[0][i] : 13'h1fff;
            checks++;
            if (got !== exp_q[0][i]) begin
                errors++;
                $display("FAIL single_byte[%0d]: got %h want %h", i, got, exp_q[0][i]);
            end
        end
        for (int i = 1; i < obs_cyc[0].size(); i++) begin
            checks++;
            if (obs_cyc[0][i] - obs_cyc[0][i-1] != 1) begin
                errors++;
                $display("FAIL single_consecutive[%0d]: gap %0d want 1", i, obs_cyc[0][i] - obs_cyc[0][i-1]);
            end
        end
        checks++;
        if (pops[0] - p0 != 10 || obusy[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_pops: got %0d pops busy=%b want 10 pops busy=0", pops[0] - p0, obusy[0]);
        end
        clear_obs(0);
    endtask

    task automatic test_round_robin();
        bit ok;
        @(posedge clk); #2;
        for (int k = 0; k < 3; k++) begin
            load_pkt(0, 0, $urandom_range(8, 2), 1'b0);
            load_pkt(0, 1, $urandom_range(8, 2), 1'b0);
        end
        refresh_heads();
        build_expected(0);
        wait_obs(0, exp_q[0].size(), 300, ok);
        wait_idle(0, 100, ok);
        checks++;
        if (obs[0].size() != exp_q[0].size()) begin
            errors++;
            $display("FAIL rr_count: got %0d bytes want %0d", obs[0].size(), exp_q[0].size());
        end
        for (int i = 0; i < exp_q[0].size(); i++) begin
            logic [12:0] got;
            got = (i < obs[0].size()) ? obs[0][i] : 13'h1fff;
            checks++;
            if (got !== exp_q[0][i]) begin
                errors++;
                $display("FAIL rr_byte[%0d]: got %h want %h", i, got, exp_q[0][i]);
            end
        end
        for (int i = 1; i < obs_cyc[0].size(); i++) begin
            int want;
            want = obs[0][i][11] ? 3 : 1;
            checks++;
            if (obs_cyc[0][i] - obs_cyc[0][i-1] != want) begin
                errors++;
                $display("FAIL rr_gap[%0d]: gap %0d want %0d", i, obs_cyc[0][i] - obs_cyc[0][i-1], want);
            end
        end
        clear_obs(0);
    endtask

    task automatic test_stall();
        bit ok, prev_stall;
        logic [7:0] held;
        @(posedge clk); #2;
        rdy_mode[0] = 1;
        load_pkt(0, 1, 20, 1'b0);
        refresh_heads();
        build_expected(0);
        prev_stall = 0;
        held       = '0;
        ok         = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (obusy[0] && !rdy[0]) begin
                checks++;
                if (rd[0] !== 3'b000) begin
                    errors++;
                    $display("FAIL stall_rd: got rd=%b want 000 while rdy=0", rd[0]);
                end
            end
            if (prev_stall) begin
                checks++;
                if (!ovld[0] || ob[0] !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got vld=%b byte=%h want vld=1 byte=%h", ovld[0], ob[0], held);
                end
            end
            prev_stall = ovld[0] && !rdy[0];
            held       = ob[0];
            if (obs[0].size() >= 20 && !obusy[0]) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok || obs[0].size() != 20) begin
            errors++;
            $display("FAIL stall_count: got %0d bytes want 20", obs[0].size());
        end
        for (int i = 0; i < exp_q[0].size(); i++) begin
            logic [12:0] got;
            got = (i < obs[0].size()) ? obs[0][i] : 13'h1fff;
            checks++;
            if (got !== exp_q[0][i]) begin
                errors++;
                $display("FAIL stall_byte[%0d]: got %h want %h", i, got, exp_q[0][i]);
            end
        end
        if (obs_cyc[0].size() == 20) begin
            checks++;
            if (obs_cyc[0][19] - obs_cyc[0][0] != 38) begin
                errors++;
                $display("FAIL stall_span: got %0d cycles want 39", obs_cyc[0][19] - obs_cyc[0][0] + 1);
            end
        end
        rdy_mode[0] = 0;
        clear_obs(0);
    endtask

    task automatic test_trunc();
        bit ok;
        int pa, pb;
        @(posedge clk); #2;
        pa = pops[3];
        pb = pops[4];
        load_pkt(1, 0, 12, 1'b1);
        load_pkt(1, 1, 5, 1'b0);
        refresh_heads();
        build_expected(1);
        wait_obs(1, 13, 200, ok);
        wait_idle(1, 100, ok);
        checks++;
        if (obs[1].size() != 13) begin
            errors++;
            $display("FAIL trunc_count: got %0d bytes want 13", obs[1].size());
        end
        for (int i = 0; i < exp_q[1].size(); i++) begin
            logic [12:0] got;
            got = (i < obs[1].size()) ? obs[1][i] : 13'h1fff;
            checks++;
            if (got !== exp_q[1][i]) begin
                errors++;
                $display("FAIL trunc_byte[%0d]: got %h want %h", i, got, exp_q[1][i]);
            end
        end
        checks++;
        if (pops[3] - pa != 12 || pops[4] - pb != 5) begin
            errors++;
            $display("FAIL trunc_pops: got %0d/%0d want 12/5", pops[3] - pa, pops[4] - pb);
        end
        clear_obs(1);
    endtask

    task automatic test_exact_max();
        bit ok;
        @(posedge clk); #2;
        load_pkt(1, 2, MAX1, 1'b0);
        refresh_heads();
        build_expected(1);
        wait_obs(1, MAX1, 100, ok);
        @(negedge clk);
        checks++;
        if (!ok || obusy[1] !== 1'b0) begin
            errors++;
            $display("FAIL exact_no_drop: got %0d bytes busy=%b want %0d bytes busy=0", obs[1].size(), obusy[1], MAX1);
        end
        for (int i = 0; i < exp_q[1].size(); i++) begin
            logic [12:0] got;
            got = (i < obs[1].size()) ? obs[1][i] : 13'h1fff;
            checks++;
            if (got !== exp_q[1][i]) begin
                errors++;
                $display("FAIL exact_byte[%0d]: got %h want %h", i, got, exp_q[1][i]);
            end
        end
        wait_idle(1, 50, ok);
        clear_obs(1);
    endtask

    task automatic test_enable();
        bit ok;
        @(posedge clk); #2;
        load_pkt(0, 0, 10, 1'b0);
        load_pkt(0, 1, 10, 1'b0);
        refresh_heads();
        build_expected(0);
        wait_obs(0, 3, 50, ok);
        @(posedge clk); #2;
        en[0] = 1'b0;
        wait_obs(0, 10, 100, ok);
        repeat (10) @(negedge clk);
        checks++;
        if (obs[0].size() != 10 || obusy[0] !== 1'b0) begin
            errors++;
            $display("FAIL en_hold: got %0d bytes busy=%b want 10 bytes busy=0", obs[0].size(), obusy[0]);
        end
        @(posedge clk); #2;
        en[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (obusy[0] !== 1'b0) begin
            errors++;
            $display("FAIL en_early: got busy=%b want 0", obusy[0]);
        end
        @(negedge clk);
        checks++;
        if (obusy[0] !== 1'b1) begin
            errors++;
            $display("FAIL en_grant: got busy=%b want 1", obusy[0]);
        end
        wait_obs(0, 20, 100, ok);
        wait_idle(0, 100, ok);
        for (int i = 0; i < exp_q[0].size(); i++) begin
            logic [12:0] got;
            got = (i < obs[0].size()) ? obs[0][i] : 13'h1fff;
            checks++;
            if (got !== exp_q[0][i]) begin
                errors++;
                $display("FAIL en_byte[%0d]: got %h want %h", i, got, exp_q[0][i]);
            end
        end
        clear_obs(0);
    endtask

    task automatic test_random(input int d);
        bit ok;
        int n;
        rdy_mode[d]  = 2;
        vld_noise[d] = 1;
        for (int r = 0; r < 4; r++) begin
            @(posedge clk); #2;
            n = 0;
            for (int p = 0; p < np_of(d); p++) begin
                for (int k = $urandom_range(3); k > 0; k--) begin
                    load_pkt(d, p, $urandom_range(14, 1), 1'b0);
                    n++;
                end
            end
            if (n == 0) load_pkt(d, 0, $urandom_range(14, 1), 1'b0);
            refresh_heads();
            build_expected(d);
            wait_obs(d, exp_q[d].size(), 2000, ok);
            wait_idle(d, 500, ok);
            checks++;
            if (!ok || obs[d].size() != exp_q[d].size()) begin
                errors++;
                $display("FAIL rand%0d_count round %0d: got %0d bytes idle=%b want %0d bytes idle=1",
                         d, r, obs[d].size(), ok, exp_q[d].size());
            end
            for (int i = 0; i < exp_q[d].size(); i++) begin
                logic [12:0] got;
                got = (i < obs[d].size()) ? obs[d][i] : 13'h1fff;
                checks++;
                if (got !== exp_q[d][i]) begin
                    errors++;
                    $display("FAIL rand%0d_byte[%0d] round %0d: got %h want %h", d, i, r, got, exp_q[d][i]);
                end
            end
            clear_obs(d);
        end
        rdy_mode[d]  = 0;
        vld_noise[d] = 0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int p0;
        @(posedge clk); #2;
        load_pkt(0, 0, 10, 1'b1);
        refresh_heads();
        wait_obs(0, 3, 50, ok);
        @(posedge clk); #2;
        checks++;
        if (obusy[0] !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy_before: got busy=%b want 1", obusy[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ob[0], ovld[0], osop[0], oeop[0], oport[0], otrunc[0], obusy[0], rd[0]} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got byte=%h vld=%b busy=%b rd=%b, want all 0",
                     ob[0], ovld[0], obusy[0], rd[0]);
        end
        p0 = pops[0];
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (pops[0] != p0) begin
            errors++;
            $display("FAIL midrst_no_pop: got %0d pops during reset want 0", pops[0] - p0);
        end
        for (int q = 0; q < 6; q++) begin
            fq[q].delete();
            mbytes[q].delete();
            mlen[q].delete();
            pkts[q] = 0;
        end
        last[0] = 1;
        last[1] = 2;
        clear_obs(0);
        refresh_heads();
        rst_n = 1'b1;
        @(posedge clk); #2;
        load_pkt(0, 1, 3, 1'b0);
        load_pkt(0, 0, 3, 1'b0);
        refresh_heads();
        build_expected(0);
        wait_obs(0, 6, 100, ok);
        wait_idle(0, 100, ok);
        for (int i = 0; i < exp_q[0].size(); i++) begin
            logic [12:0] got;
            got = (i < obs[0].size()) ? obs[0][i] : 13'h1fff;
            checks++;
            if (got !== exp_q[0][i]) begin
                errors++;
                $display("FAIL postrst_byte[%0d]: got %h want %h", i, got, exp_q[0][i]);
            end
        end
        clear_obs(0);
    endtask

    initial begin
        rst_n  = 1'b0;
        checks = 0;
        errors = 0;
        cyc    = 0;
        last[0] = 1;
        last[1] = 2;
        for (int d = 0; d < 2; d++) begin
            en[d]        = 1'b1;
            rdy[d]       = 1'b1;
            rdy_mode[d]  = 0;
            vld_noise[d] = 0;
            avail[d]     = '0;
            vld[d]       = '0;
            eop[d]       = '0;
            pbyte[d]     = '0;
        end
        test_reset();
        test_single_pkt();
        test_round_robin();
        test_stall();
        test_trunc();
        test_exact_max();
        test_enable();
        test_random(0);
        test_random(1);
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/udp_port_drain_arbiter.md
Name: udp_port_drain_arbiter

Overview:
- Packet-atomic round-robin arbiter that drains the per-port UDP payload byte FIFOs of the Gbit MAC RX support chain.
- Merges them onto a single byte stream, tagged with the port index, for the downstream command/control and DAC consumers.
- Owns the per-port byte read strobes, replacing any hard-tied read enables.
- Enforces a maximum packet length so a corrupt FIFO cannot lock the shared stream.

Parameters:
- P_NUM_PORTS, 2, number of UDP port FIFOs arbitrated (1..16).
- P_MAX_PKT_BYTES, 1472, maximum payload bytes per packet before forced truncation (1..65535).
- P_IDX_W, $clog2(P_NUM_PORTS) (min 1), width of the port index.

Ports:
- i_rxmac_clk  in  1  clock; all logic in this domain.
- i_rxmac_srst  in  1  reset, asynchronous, active-low.
- i_en  in  1  1 = new grants allowed; 0 = finish the current packet, then hold in IDLE.
- i_port_pkt_avail  in  P_NUM_PORTS  bit p = FIFO p holds at least one complete packet.
- i_port_byte  in  8*P_NUM_PORTS  FWFT head byte of each FIFO; port p is bits [8p+7:8p].
- i_port_byte_vld  in  P_NUM_PORTS  head byte of FIFO p valid.
- i_port_eop  in  P_NUM_PORTS  head byte of FIFO p is the last byte of its packet.
- o_port_byte_rd  out  P_NUM_PORTS  pop strobe, one-hot or zero.
- o_byte  out  8  merged stream data.
- o_byte_vld  out  1  merged stream valid.
- o_byte_sop  out  1  first byte of packet.
- o_byte_eop  out  1  last byte of packet (real or forced).
- o_byte_port  out  P_IDX_W  source port of the current byte.
- i_byte_rdy  in  1  downstream accepts the byte when vld and rdy are both high.
- o_pkt_trunc  out  1  one-cycle pulse: packet hit P_MAX_PKT_BYTES without eop.
- o_busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values: FSM=IDLE, rr_ptr=P_NUM_PORTS-1, grant=0, byte_cnt=0, sop_pend=0. All outputs 0 while reset is asserted. Reset mid-packet abandons the packet; no bytes are popped during reset.
- States: IDLE, ARB, XFER, DROP.
- IDLE -> ARB when i_en=1 and |i_port_pkt_avail.
- ARB (one cycle):
  - Grant the first port with pkt_avail=1, searching rr_ptr+1, rr_ptr+2, ... modulo P_NUM_PORTS.
  - Register grant; rr_ptr <= grant; byte_cnt <= 0; sop_pend <= 1; go to XFER.
  - If avail has dropped to 0, return to IDLE with no grant.
- XFER, granted port g, combinational pass-through:
  - o_byte = i_port_byte[g]; o_byte_vld = i_port_byte_vld[g]; o_byte_port = g; o_byte_sop = sop_pend.
  - o_port_byte_rd[g] = vld & rdy. No other port is ever popped.
  - Each accepted byte: byte_cnt++, sop_pend <= 0.
  - o_byte_eop = i_port_eop[g] OR (byte_cnt == P_MAX_PKT_BYTES-1).
  - Accepted byte with real eop -> IDLE.
  - Accepted byte with forced eop only -> o_pkt_trunc=1 for that cycle, then DROP.
  - Real eop on the P_MAX_PKT_BYTES-th byte is a normal end: no trunc, no DROP.
- DROP: o_byte_vld=0; o_port_byte_rd[g] = i_port_byte_vld[g], ignoring rdy. Popped eop -> IDLE.
- Minimum gap: IDLE->ARB->XFER gives 2 idle cycles between packets. Back-to-back grants always pass through IDLE.
- Fairness: packet-granular round-robin. After serving port g, port g has lowest priority in the next ARB.
- i_en deassert mid-packet has no effect until that packet's eop.
- Counters: byte_cnt is 16 bits and saturating, never wraps. rr_ptr wraps modulo P_NUM_PORTS, including non-power-of-2 counts.
- Simultaneous events in the XFER cycle accepting eop: new avail requests are sampled in the following IDLE cycle. The eop byte's rd and the transition happen in the same cycle.
- Stalls: vld=0 or rdy=0 holds state, count and outputs indefinitely, with no timeout.

Test Plan:
- N=2, port0 pkt of 10 bytes 0x00..0x09 with rdy=1 -> o_byte 0x00..0x09 on 10 consecutive cycles, sop on 0x00, eop on 0x09, o_byte_port=0, rd[0] pulsed 10 times, IDLE afterwards.
- Both ports hold 3 packets each with avail held -> service order 0,1,0,1,0,1. Exactly 2 idle cycles between each eop and the next sop.
- Port1 pkt 20 bytes, rdy toggled 1,0 every cycle -> 20 bytes delivered over 39 cycles, in order, no rd while rdy=0, data stable while stalled.
- P_MAX_PKT_BYTES=8, port0 pkt of 12 bytes -> 8 bytes out, eop on the 8th, o_pkt_trunc high on the same cycle. Remaining 4 bytes are popped with o_byte_vld=0, then a port1 packet is served normally.
- P_MAX_PKT_BYTES=8, 8-byte packet with real eop -> eop on byte 8, o_pkt_trunc stays 0, no DROP.
- i_en=0 asserted at byte 3 of a 10-byte packet -> packet completes, no further grants while avail=1. Re-enabling i_en leads to a grant 1 cycle later. Reset asserted mid-packet -> all outputs 0 immediately and FSM in IDLE.
